// File: rtl/alu_operand_decoder_pkg.sv
// Shared encodings for the ALU operand decode stage and the ALU itself.
package alu_operand_decoder_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    // RV32I major opcodes handled by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 ALU operation encodings, shared with the ALU
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // Legal funct7 patterns for register and shift-immediate forms
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded entry as held in the stage output register
    typedef struct packed {
        logic [XLEN-1:0]    aluin1;
        logic [XLEN-1:0]    aluin2;
        logic [2:0]         funct3;
        logic               funct7;
        logic [RADDR_W-1:0] rd_addr;
        logic               wb_en;
        logic               illegal;
    } dec_t;

endpackage

// File: rtl/alu_operand_decoder_imm_gen.sv
// Immediate extraction for the decode stage: I, S and U formats.
// Only bits [31:7] carry immediate data, so the opcode field is not an input.
module alu_operand_decoder_imm_gen
    import alu_operand_decoder_pkg::*;
(
    input  logic [31:7]     inst,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_u
);

    // Sign extension always comes from inst[31]
    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u = {inst[31:12], 12'b0};

endmodule

// File: rtl/alu_operand_decoder.sv
// Single-stage RV32I decode feeding the combinational ALU, with a
// valid/ready handshake on both sides and a flush for branch redirect.
module alu_operand_decoder
    import alu_operand_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    aluin1,
    output logic [XLEN-1:0]    aluin2,
    output logic [2:0]         funct3,
    output logic               funct7,
    output logic [RADDR_W-1:0] rd_addr,
    output logic               wb_en,
    output logic               illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic            has_rd;
    logic            load;
    dec_t            dec_d;
    dec_t            dec_q;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    alu_operand_decoder_imm_gen u_imm_gen (
        .inst  (in_inst[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_u (imm_u)
    );

    // Operand selection and legality check for the presented instruction
    always_comb begin
        dec_d         = '0;
        dec_d.funct3  = ALU_ADD;
        dec_d.rd_addr = in_inst[11:7];
        has_rd        = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_d.aluin1 = in_rs1_data;
                dec_d.aluin2 = in_rs2_data;
                dec_d.funct3 = f3;
                dec_d.funct7 = in_inst[30];
                has_rd       = 1'b1;
                if (f7 != F7_BASE && f7 != F7_ALT)
                    dec_d.illegal = 1'b1;
                else if (f7 == F7_ALT && f3 != ALU_ADD && f3 != ALU_SR)
                    dec_d.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_d.aluin1 = in_rs1_data;
                dec_d.aluin2 = imm_i;
                dec_d.funct3 = f3;
                // inst[30] is an immediate bit for ADDI and friends, never SUB
                dec_d.funct7 = (f3 == ALU_SR) ? in_inst[30] : 1'b0;
                has_rd       = 1'b1;
                if (f3 == ALU_SLL && f7 != F7_BASE)
                    dec_d.illegal = 1'b1;
                else if (f3 == ALU_SR && f7 != F7_BASE && f7 != F7_ALT)
                    dec_d.illegal = 1'b1;
            end
            OPC_LUI: begin
                dec_d.aluin2 = imm_u;
                has_rd       = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.aluin1 = in_pc;
                dec_d.aluin2 = imm_u;
                has_rd       = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU computes the link value pc+4; the target is resolved elsewhere
                dec_d.aluin1 = in_pc;
                dec_d.aluin2 = XLEN'(4);
                has_rd       = 1'b1;
            end
            OPC_LOAD: begin
                dec_d.aluin1 = in_rs1_data;
                dec_d.aluin2 = imm_i;
                has_rd       = 1'b1;
            end
            OPC_STORE: begin
                dec_d.aluin1 = in_rs1_data;
                dec_d.aluin2 = imm_s;
            end
            OPC_BRANCH: begin
                // ALU only produces the compare; inst[13] picks the unsigned flavours
                dec_d.aluin1 = in_rs1_data;
                dec_d.aluin2 = in_rs2_data;
                dec_d.funct3 = in_inst[13] ? ALU_SLTU : ALU_SLT;
            end
            default: begin
                dec_d.illegal = 1'b1;
            end
        endcase
        // Illegal entries still flow, but carry neutral operands so the ALU idles
        if (dec_d.illegal) begin
            dec_d.aluin1 = '0;
            dec_d.aluin2 = '0;
            dec_d.funct3 = ALU_ADD;
            dec_d.funct7 = 1'b0;
        end
        dec_d.wb_en = has_rd && (dec_d.rd_addr != '0) && !dec_d.illegal;
    end

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Output register bank; flush kills validity but leaves the data registers alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dec_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            dec_q     <= dec_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign aluin1  = dec_q.aluin1;
    assign aluin2  = dec_q.aluin2;
    assign funct3  = dec_q.funct3;
    assign funct7  = dec_q.funct7;
    assign rd_addr = dec_q.rd_addr;
    assign wb_en   = dec_q.wb_en;
    assign illegal = dec_q.illegal;

endmodule

// File: tb/tb_alu_operand_decoder.sv
// Directed bench for alu_operand_decoder: hand-encoded RV32I words with
// hand-computed ALU fields, plus handshake, stall, flush and reset cases.
module tb_alu_operand_decoder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [2:0]  funct3;
    logic        funct7;
    logic [4:0]  rd_addr;
    logic        wb_en;
    logic        illegal;

    int n_cmp = 0;
    int n_mis = 0;

    alu_operand_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluin1      (aluin1),
        .aluin2      (aluin2),
        .funct3      (funct3),
        .funct7      (funct7),
        .rd_addr     (rd_addr),
        .wb_en       (wb_en),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid    = 1'b1;
        in_inst     = inst;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    // Present one instruction for one cycle; returns just after the accepting edge
    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clk);
        drive(inst, pc, rs1, rs2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_fields(input string tag,
                                 input logic [31:0] a1, input logic [31:0] a2,
                                 input logic [31:0] f3, input logic [31:0] f7,
                                 input logic [31:0] rd, input logic [31:0] wb,
                                 input logic [31:0] ill);
        chk({tag, ".valid"},   32'(out_valid), 32'd1);
        chk({tag, ".aluin1"},  aluin1, a1);
        chk({tag, ".aluin2"},  aluin2, a2);
        chk({tag, ".funct3"},  32'(funct3), f3);
        chk({tag, ".funct7"},  32'(funct7), f7);
        chk({tag, ".rd_addr"}, 32'(rd_addr), rd);
        chk({tag, ".wb_en"},   32'(wb_en), wb);
        chk({tag, ".illegal"}, 32'(illegal), ill);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready), 32'd1);
        chk("rst.aluin1",    aluin1, 32'd0);
        chk("rst.wb_en",     32'(wb_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SUB x3,x1,x2
        send(32'h402081B3, 32'h100, 32'd7, 32'h8000000A);
        expect_fields("sub", 32'd7, 32'h8000000A, 32'd0, 32'd1, 32'd3, 32'd1, 32'd0);

        // Back-to-back: ADDI x1,x0,-1 then SRAI x5,x6,4
        send(32'hFFF00093, 32'h104, 32'd0, 32'd0);
        expect_fields("addi_m1", 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0);
        send(32'h40435293, 32'h108, 32'h80000000, 32'd0);
        expect_fields("srai", 32'h80000000, 32'h00000404, 32'd5, 32'd1, 32'd5, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        // ADDI x2,x0,0x400: inst[30] set but must not become SUB
        send(32'h40000113, 32'h10C, 32'd5, 32'd0);
        expect_fields("addi_b30", 32'd5, 32'h00000400, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0);
        @(posedge clk);
        #1;

        // Stall: SUB held while LUI waits at the input
        out_ready = 1'b0;
        send(32'h402081B3, 32'h110, 32'd7, 32'h8000000A);
        expect_fields("stall_sub", 32'd7, 32'h8000000A, 32'd0, 32'd1, 32'd3, 32'd1, 32'd0);
        @(negedge clk);
        drive(32'h123453B7, 32'h114, 32'hDEAD0000, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d.aluin1", i), aluin1, 32'd7);
            chk($sformatf("stall%0d.aluin2", i), aluin2, 32'h8000000A);
            chk($sformatf("stall%0d.rd_addr", i), 32'(rd_addr), 32'd3);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_fields("lui", 32'd0, 32'h12345000, 32'd0, 32'd0, 32'd7, 32'd1, 32'd0);

        // JAL x1 near top of memory: link value wraps silently
        send(32'h000000EF, 32'hFFFFFFFC, 32'd0, 32'd0);
        expect_fields("jal", 32'hFFFFFFFC, 32'd4, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0);

        // Flush while stalled drops the held entry and accepts nothing
        out_ready = 1'b0;
        @(negedge clk);
        drive(32'hFFFFF417, 32'h2000, 32'd0, 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_stall.out_valid", 32'(out_valid), 32'd0);
        chk("flush_stall.aluin1_kept", aluin1, 32'hFFFFFFFC);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("flush_after%0d.out_valid", i), 32'(out_valid), 32'd0);
        end

        // Flush beats a same-cycle accept
        @(negedge clk);
        drive(32'hFFFFF417, 32'h2000, 32'd0, 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_acc.out_valid", 32'(out_valid), 32'd0);
        chk("flush_acc.aluin2_kept", aluin2, 32'd4);

        // AUIPC x8,0xFFFFF
        send(32'hFFFFF417, 32'h2000, 32'd0, 32'd0);
        expect_fields("auipc", 32'h2000, 32'hFFFFF000, 32'd0, 32'd0, 32'd8, 32'd1, 32'd0);

        // JAL x0: no writeback
        send(32'h0000006F, 32'h3000, 32'd0, 32'd0);
        expect_fields("jal_x0", 32'h3000, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // LW x4,8(x1) and SW x2,-4(x1)
        send(32'h0080A203, 32'h3004, 32'h1000, 32'd0);
        expect_fields("lw", 32'h1000, 32'd8, 32'd0, 32'd0, 32'd4, 32'd1, 32'd0);
        send(32'hFE20AE23, 32'h3008, 32'h1000, 32'h55);
        expect_fields("sw", 32'h1000, 32'hFFFFFFFC, 32'd0, 32'd0, 32'h1C, 32'd0, 32'd0);

        // BEQ -> SLT, BLTU -> SLTU
        send(32'h00208063, 32'h300C, 32'd11, 32'd22);
        expect_fields("beq", 32'd11, 32'd22, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        send(32'h0020E063, 32'h3010, 32'd33, 32'd44);
        expect_fields("bltu", 32'd33, 32'd44, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0);

        // Illegal encodings still flow with out_valid
        send(32'h0000017F, 32'h3014, 32'd9, 32'd9);
        expect_fields("opc7f", 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd1);
        send(32'h022081B3, 32'h3018, 32'd9, 32'd9);
        expect_fields("mul", 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd1);
        send(32'h40109093, 32'h301C, 32'd9, 32'd0);
        expect_fields("slli_f7", 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1);
        send(32'h402091B3, 32'h3020, 32'd9, 32'd9);
        expect_fields("alt_sll", 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd1);

        // Reset mid-stream with a held entry
        send(32'h402081B3, 32'h3024, 32'd7, 32'h8000000A);
        out_ready = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.in_ready",  32'(in_ready), 32'd1);
        chk("mrst.aluin1",    aluin1, 32'd0);
        chk("mrst.aluin2",    aluin2, 32'd0);
        chk("mrst.funct7",    32'(funct7), 32'd0);
        chk("mrst.rd_addr",   32'(rd_addr), 32'd0);
        chk("mrst.wb_en",     32'(wb_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
